// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and the
// latency helper. The BARREL_ROTATE_EN macro controls whether op 11 builds
// real rotate muxes or aliases to SRL.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTR = 2'b11
  } shift_op_t;

  // Pipeline depth: number of stage registers needed to cover every shift bit.
  function automatic int nstage(input int shamt_w, input int levels);
    return (shamt_w + levels - 1) / levels;
  endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One combinational level of the barrel shifter: moves the word by a fixed
// distance DIST when en_i is set. With BARREL_ROTATE_EN defined, OP_ROTR
// wraps the low bits to the top; otherwise it behaves as SRL.
module barrel_shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  shift_op_t        op_i,
  output logic [WIDTH-1:0] data_o
);

  // Select the shifted/rotated word or pass through when this bit of shamt is clear.
  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (op_i)
        OP_SLL:  data_o = data_i << DIST;
        // MSB is still the original sign bit because earlier levels also ran SRA.
        OP_SRA:  data_o = $signed(data_i) >>> DIST;
`ifdef BARREL_ROTATE_EN
        OP_ROTR: data_o = (data_i >> DIST) | (data_i << (WIDTH - DIST));
`endif
        // SRL, and op 11 when the rotate muxes are not built.
        default: data_o = data_i >> DIST;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined shift/rotate unit with valid/ready flow control. Shift level j
// moves by 2^j; LEVELS_PER_STAGE levels sit between pipeline registers, and
// shamt/op/tag travel with the data. Optional rotate: BARREL_ROTATE_EN.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH            = 32,
  parameter int SHAMT_W          = $clog2(WIDTH),
  parameter int LEVELS_PER_STAGE = 2,
  parameter int TAG_W            = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int NSTAGE = nstage(SHAMT_W, LEVELS_PER_STAGE);

  typedef struct packed {
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    shift_op_t          op;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  stage_t [NSTAGE-1:0] stg_q, stg_d;
  stage_t [NSTAGE-1:0] src_stg;   // what feeds each stage's mux levels
  stage_t [NSTAGE-1:0] nxt_stg;   // post-shift value each stage would load
  logic   [NSTAGE-1:0] vld_q, vld_d;
  logic   [NSTAGE-1:0] src_vld;
  logic   [NSTAGE-1:0] take;      // stage register loads this cycle

  // Stage inputs: stage 0 from the ports, the rest from the previous register.
  for (genvar s = 0; s < NSTAGE; s++) begin : g_src
    if (s == 0) begin : g_head
      assign src_stg[s] = '{data: in_data, shamt: in_shamt,
                            op: shift_op_t'(in_op), tag: in_tag};
    end else begin : g_body
      assign src_stg[s] = stg_q[s-1];
    end
  end

  if (NSTAGE == 1) begin : g_vld1
    assign src_vld = in_valid;
  end else begin : g_vldn
    assign src_vld = {vld_q[NSTAGE-2:0], in_valid};
  end

  // Mux levels, LSB-first; the first level of each stage restarts from that stage's input.
  for (genvar j = 0; j < SHAMT_W; j++) begin : g_lvl
    localparam int S = j / LEVELS_PER_STAGE;
    logic [WIDTH-1:0] d_in, d_out;
    if (j % LEVELS_PER_STAGE == 0) begin : g_first
      assign d_in = src_stg[S].data;
    end else begin : g_chain
      assign d_in = g_lvl[j-1].d_out;
    end
    barrel_shift_level #(.WIDTH(WIDTH), .DIST(1 << j)) u_lvl (
      .data_i (d_in),
      .en_i   (src_stg[S].shamt[j]),
      .op_i   (src_stg[S].op),
      .data_o (d_out)
    );
  end

  // Post-shift stage value: data from the stage's last level, sideband passed through.
  for (genvar s = 0; s < NSTAGE; s++) begin : g_nxt
    localparam int LAST = (((s + 1) * LEVELS_PER_STAGE < SHAMT_W) ?
                           (s + 1) * LEVELS_PER_STAGE : SHAMT_W) - 1;
    assign nxt_stg[s] = '{data: g_lvl[LAST].d_out, shamt: src_stg[s].shamt,
                          op: src_stg[s].op, tag: src_stg[s].tag};
  end

  // A stage can load when it or any stage downstream is empty, or the sink is ready.
  always_comb begin
    logic chain;
    chain = out_ready;
    take  = '0;
    for (int s = NSTAGE - 1; s >= 0; s--) begin
      chain   = chain | ~vld_q[s];
      take[s] = chain;
    end
  end

  // Next-state: loading stages take the upstream valid; data only updates on a real op.
  always_comb begin
    vld_d = vld_q;
    stg_d = stg_q;
    for (int s = 0; s < NSTAGE; s++) begin
      if (take[s]) begin
        vld_d[s] = src_vld[s];
        if (src_vld[s]) stg_d[s] = nxt_stg[s];
      end
    end
  end

  // Pipeline registers; reset empties every slot and zeroes the payload.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      stg_q <= '0;
    end else begin
      vld_q <= vld_d;
      stg_q <= stg_d;
    end
  end

  assign in_ready  = take[0];
  assign out_valid = vld_q[NSTAGE-1];
  assign out_data  = stg_q[NSTAGE-1].data;
  assign out_tag   = stg_q[NSTAGE-1].tag;

  // Shift amount and op are fully consumed by the time they reach the last register.
  logic unused_tail;
  assign unused_tail = ^{stg_q[NSTAGE-1].shamt, stg_q[NSTAGE-1].op};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=32, 2 levels/stage, latency 3).
// Honours BARREL_ROTATE_EN for the expected ROTR results.
module tb_pipelined_barrel_shifter;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  pipelined_barrel_shifter #(.WIDTH(32), .LEVELS_PER_STAGE(2), .TAG_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   done;

  logic        prev_v, prev_r;
  logic [31:0] prev_d;
  logic [3:0]  prev_t;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_fn(logic [31:0] d, logic [4:0] sh, logic [1:0] op);
    case (op)
      2'b00:   return d << sh;
      2'b01:   return d >> sh;
      2'b10:   return $signed(d) >>> sh;
`ifdef BARREL_ROTATE_EN
      default: return (d >> sh) | (d << (32 - int'(sh)));
`else
      default: return d >> sh;
`endif
    endcase
  endfunction

  function automatic void push_exp(logic [31:0] d, logic [3:0] tg, bit lat);
    exp_t e;
    e.data = d; e.tag = tg; e.acc = cyc; e.lat = lat;
    sb.push_back(e);
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor: stall stability, then scoreboard pop on every consumed result.
  always @(negedge clock) begin
    if (reset) begin
      prev_v = 1'b0;
      prev_r = 1'b1;
    end else begin
      if (prev_v && !prev_r) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_d);
        chk("hold_tag", out_tag, prev_t);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_output", out_tag, 'hF0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("data", out_data, e.data);
          chk("tag", out_tag, e.tag);
          if (e.lat) chk("latency", cyc - e.acc, 3);
        end
      end
      prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_t = out_tag;
    end
  end

  // Present one op (called at posedge+1), wait for acceptance, record the expectation.
  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] op,
                      input logic [3:0] tg, input logic [31:0] expd, input bit lat);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_op = op; in_tag = tg;
    do begin
      @(negedge clock);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) chk("accept_timeout", in_ready, 1);
    else push_exp(expd, tg, lat);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [3:0] tg);
    logic [31:0] d;
    logic [4:0]  sh;
    logic [1:0]  op;
    d  = $urandom();
    sh = 5'($urandom_range(0, 31));
    op = 2'($urandom_range(0, 3));
    send(d, sh, op, tg, ref_fn(d, sh, op), 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    chk(tag, sb.size(), 0);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1; done = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    @(posedge clock); #1;

    // Directed ops from the datasheet.
    send(32'h0000_00FF, 5'd8, 2'b00, 4'd1, 32'h0000_FF00, 1'b1);
    wait_drain("drain_sll");
    send(32'h8000_0000, 5'd31, 2'b10, 4'd2, 32'hFFFF_FFFF, 1'b0);
    send(32'h8000_0000, 5'd31, 2'b01, 4'd3, 32'h0000_0001, 1'b0);
    for (int op = 0; op < 4; op++)
      send(32'hA5A5_3C3C, 5'd0, 2'(op), 4'(4 + op), 32'hA5A5_3C3C, 1'b0);
`ifdef BARREL_ROTATE_EN
    send(32'h0000_0001, 5'd1, 2'b11, 4'd8, 32'h8000_0000, 1'b0);
`else
    send(32'h0000_0001, 5'd1, 2'b11, 4'd8, 32'h0000_0000, 1'b0);
`endif
    send(32'h8000_0000, 5'd1, 2'b11, 4'd9, 32'h4000_0000, 1'b0);
    wait_drain("drain_directed");

    // Back-to-back burst, tags 0..9, with the sink stalled for cycles 4-7.
    fork
      for (int i = 0; i < 10; i++) send_rand(4'(i));
      begin
        repeat (4) begin @(posedge clock); #1; end
        out_ready = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_burst");

    // Full pipeline: accept at the head while the tail is consumed.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(4'(10 + i));
    @(negedge clock);
    chk("full_stalled_in_ready", in_ready, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h1234_5678; in_shamt = 5'd4; in_op = 2'b00; in_tag = 4'd13;
    @(negedge clock);
    chk("full_in_ready", in_ready, 1);
    if (in_ready) push_exp(32'h2345_6780, 4'd13, 1'b0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("full_in_ready_after", in_ready, 1);
    @(posedge clock); #1;
    wait_drain("drain_full");

    // Reset with three ops in flight: nothing may emerge afterwards.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_rand(4'(i));
    reset = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_tag", out_tag, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    repeat (8) begin @(posedge clock); #1; end
    send(32'hF000_000F, 5'd4, 2'b10, 4'd7, 32'hFF00_0000, 1'b1);
    wait_drain("drain_post_reset");

    // Random traffic against a randomly stalling sink.
    fork
      begin
        for (int i = 0; i < 40; i++) send_rand(4'(i));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("drain_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
